sys_ctrl_rx: RTL and testbench
==============================

# sys_ctrl_rx

Command decoder and register-access sequencer that sits directly upstream of the register file. It takes parallel bytes from the UART receiver, parses write (AA, addr, data) and read (BB, addr) frames, and drives the register file's WrEN/RdEN/Address/WrData port. It captures RdData on RdData_VLD and hands it to the UART transmitter over a valid/busy handshake.

## Interface
Parameters:
- CMD_WR, 8'hAA, write-frame command byte
- CMD_RD, 8'hBB, read-frame command byte
- RD_TIMEOUT, 4, max cycles in RD_WAIT for RdData_VLD; minimum 2

Ports:
- clk  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- RX_P_DATA  in  8  received byte
- RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
- WrEN  out  1  register-file write strobe
- RdEN  out  1  register-file read strobe
- Address  out  4  register address, from addr byte bits [3:0]; bits [7:4] ignored
- WrData  out  8  write data
- RdData  in  8  register-file read data
- RdData_VLD  in  1  register-file read-data valid
- TX_P_DATA  out  8  byte to transmitter
- TX_D_VLD  out  1  transmit request
- TX_BUSY  in  1  transmitter busy
- CMD_ERR  out  1  one-cycle pulse, unknown command byte in IDLE
- OVR_ERR  out  1  one-cycle pulse, byte dropped (RD_WAIT/TX_SEND) or read timeout

## Operation
- All outputs registered. Reset value of every output is 0. Reset forces state IDLE and clears the timeout counter, from any state and at any time.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
- IDLE: a byte with RX_D_VLD=1 selects the next state. CMD_WR goes to WR_ADDR. CMD_RD goes to RD_ADDR. Any other value pulses CMD_ERR and stays in IDLE.
- WR_ADDR: a byte latches Address and moves to WR_DATA.
- WR_DATA: a byte latches WrData, WrEN=1 for exactly one cycle, then IDLE.
- RD_ADDR: a byte latches Address, RdEN=1 for exactly one cycle, then RD_WAIT with the counter cleared.
- RD_WAIT:
  - RdData_VLD=1: capture RdData into TX_P_DATA, go to TX_SEND.
  - Counter reaches RD_TIMEOUT: pulse OVR_ERR, go to IDLE.
  - Otherwise the counter increments.
- TX_SEND: TX_D_VLD=1 with TX_P_DATA stable. The transfer completes in the cycle where TX_D_VLD=1 and TX_BUSY=0. On the next cycle TX_D_VLD=0 and state returns to IDLE.
- Any RX_D_VLD in RD_WAIT or TX_SEND: byte discarded, OVR_ERR pulsed, state unaffected. If this coincides with a timeout, a single OVR_ERR pulse is emitted.
- WrEN and RdEN are never high together. Address and WrData hold their last value between accesses.
- Frames have no inter-byte timeout. A partial frame waits indefinitely for its next byte.

## Timing
- RX strobe at cycle N in WR_DATA: WrEN=1 at N+1, state IDLE at N+1.
- RX strobe at cycle N in RD_ADDR: RdEN=1 at N+1.
- Register-file response: RdData_VLD at N+2, TX_D_VLD=1 at N+3.
- RdData_VLD at cycle M in RD_WAIT: TX_D_VLD=1 at M+1.
- TX_BUSY low while TX_D_VLD=1 at cycle K: TX_D_VLD=0 at K+1.
- Back-to-back frames: the command byte of the next frame may arrive the cycle after WrEN and is accepted.
- Timeout: OVR_ERR fires RD_TIMEOUT+1 cycles after RdEN.

## Structure
- Shared package sys_pkg holds:
  - the state encoding (3-bit localparams)
  - default CMD_WR and CMD_RD values
  - ADDR_W=4 and DATA_W=8
- These constants are shared with the register file and the UART blocks.
- Single module. The timeout counter is 3 bits and inline; no sub-module.

## Test plan
- Write frame: AA,03,5C strobes spaced 3 cycles apart -> one WrEN pulse with Address=3, WrData=5C. No RdEN. Return to IDLE.
- Read frame: BB,02 with a model returning RdData=21 and RdData_VLD one cycle after RdEN -> TX_D_VLD with TX_P_DATA=21. Hold TX_BUSY=1 for 5 cycles -> TX_D_VLD stays high, then drops one cycle after TX_BUSY falls.
- Unknown command: byte 7F in IDLE -> CMD_ERR pulse, no WrEN/RdEN. A following AA,01,FF completes normally.
- Read timeout: BB,04 with RdData_VLD never asserted -> OVR_ERR exactly RD_TIMEOUT+1 cycles after RdEN. State returns to IDLE and TX_D_VLD stays 0.
- Overrun: byte 33 strobed during TX_SEND -> OVR_ERR pulse, TX_P_DATA unchanged, byte not parsed as a command.
- Reset mid-operation: assert RST after AA,05 -> all outputs 0 immediately. After release, byte 05 in IDLE gives CMD_ERR, not a write.

Source files
------------

// File: rtl/sys_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sys_pkg
//  Description : Constants shared by the system controller, register file and
//                UART blocks: bus widths, command bytes, controller states.
//  Revision    : 1.0 - initial release
// ============================================================================
package sys_pkg;

  // Register-file bus widths
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  // Default frame command bytes
  localparam logic [DATA_W-1:0] CMD_WR_DEFAULT = 8'hAA;
  localparam logic [DATA_W-1:0] CMD_RD_DEFAULT = 8'hBB;

  // Receive-controller state encoding
  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WR_ADDR = 3'd1;
  localparam state_t ST_WR_DATA = 3'd2;
  localparam state_t ST_RD_ADDR = 3'd3;
  localparam state_t ST_RD_WAIT = 3'd4;
  localparam state_t ST_TX_SEND = 3'd5;

endpackage
`default_nettype wire

// File: rtl/sys_ctrl_rx.sv
`default_nettype none
// ============================================================================
//  Module      : sys_ctrl_rx
//  Description : Parses UART write (CMD_WR, addr, data) and read (CMD_RD,
//                addr) frames, drives the register-file access port and
//                forwards read data to the UART transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
module sys_ctrl_rx
  import sys_pkg::*;
#(
  parameter logic [DATA_W-1:0] CMD_WR     = CMD_WR_DEFAULT,
  parameter logic [DATA_W-1:0] CMD_RD     = CMD_RD_DEFAULT,
  // Cycles allowed in RD_WAIT; must lie in 2..7 to fit the 3-bit counter
  parameter int                RD_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [DATA_W-1:0] RX_P_DATA,
  input  logic              RX_D_VLD,
  output logic              WrEN,
  output logic              RdEN,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WrData,
  input  logic [DATA_W-1:0] RdData,
  input  logic              RdData_VLD,
  output logic [DATA_W-1:0] TX_P_DATA,
  output logic              TX_D_VLD,
  input  logic              TX_BUSY,
  output logic              CMD_ERR,
  output logic              OVR_ERR
);

  localparam logic [2:0] TIMEOUT_CNT = 3'(RD_TIMEOUT);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;

  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [DATA_W-1:0] tx_p_data_q, tx_p_data_d;
  logic              tx_d_vld_q, tx_d_vld_d;
  logic              cmd_err_q, cmd_err_d;
  logic              ovr_err_q, ovr_err_d;

  logic              rd_timeout;
  logic              is_known_cmd;

  // Read data has priority: a timeout only counts when no data arrives that cycle
  assign rd_timeout   = (state_q == ST_RD_WAIT) && !RdData_VLD && (cnt_q == TIMEOUT_CNT);
  assign is_known_cmd = (RX_P_DATA == CMD_WR) || (RX_P_DATA == CMD_RD);

  // State and timeout-counter registers
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and timeout-counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_WR) begin
            state_d = ST_WR_ADDR;
          end else if (RX_P_DATA == CMD_RD) begin
            state_d = ST_RD_ADDR;
          end
        end
      end
      ST_WR_ADDR: begin
        if (RX_D_VLD) state_d = ST_WR_DATA;
      end
      ST_WR_DATA: begin
        if (RX_D_VLD) state_d = ST_IDLE;
      end
      ST_RD_ADDR: begin
        if (RX_D_VLD) begin
          state_d = ST_RD_WAIT;
          cnt_d   = 3'd0;
        end
      end
      ST_RD_WAIT: begin
        if (RdData_VLD) begin
          state_d = ST_TX_SEND;
        end else if (rd_timeout) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_TX_SEND: begin
        if (tx_d_vld_q && !TX_BUSY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; strobes default low, data holds
  always_comb begin
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    cmd_err_d   = 1'b0;
    ovr_err_d   = 1'b0;
    tx_d_vld_d  = 1'b0;
    address_d   = address_q;
    wr_data_d   = wr_data_q;
    tx_p_data_d = tx_p_data_q;
    case (state_q)
      ST_IDLE: begin
        cmd_err_d = RX_D_VLD && !is_known_cmd;
      end
      ST_WR_ADDR: begin
        if (RX_D_VLD) address_d = RX_P_DATA[ADDR_W-1:0];
      end
      ST_WR_DATA: begin
        if (RX_D_VLD) begin
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
        end
      end
      ST_RD_ADDR: begin
        if (RX_D_VLD) begin
          address_d = RX_P_DATA[ADDR_W-1:0];
          rd_en_d   = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        // A dropped byte and a timeout in the same cycle share one pulse
        ovr_err_d = RX_D_VLD || rd_timeout;
        if (RdData_VLD) begin
          tx_p_data_d = RdData;
          tx_d_vld_d  = 1'b1;
        end
      end
      ST_TX_SEND: begin
        ovr_err_d  = RX_D_VLD;
        // Request stays up until the transmitter is seen not busy
        tx_d_vld_d = TX_BUSY;
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      address_q   <= '0;
      wr_data_q   <= '0;
      tx_p_data_q <= '0;
      tx_d_vld_q  <= 1'b0;
      cmd_err_q   <= 1'b0;
      ovr_err_q   <= 1'b0;
    end else begin
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      address_q   <= address_d;
      wr_data_q   <= wr_data_d;
      tx_p_data_q <= tx_p_data_d;
      tx_d_vld_q  <= tx_d_vld_d;
      cmd_err_q   <= cmd_err_d;
      ovr_err_q   <= ovr_err_d;
    end
  end

  assign WrEN      = wr_en_q;
  assign RdEN      = rd_en_q;
  assign Address   = address_q;
  assign WrData    = wr_data_q;
  assign TX_P_DATA = tx_p_data_q;
  assign TX_D_VLD  = tx_d_vld_q;
  assign CMD_ERR   = cmd_err_q;
  assign OVR_ERR   = ovr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sys_ctrl_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sys_ctrl_rx
//  Description : Self-checking bench for sys_ctrl_rx with a register-file
//                model and per-kind expected-result queues.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sys_ctrl_rx;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       RST;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD;
  logic       WrEN;
  logic       RdEN;
  logic [3:0] Address;
  logic [7:0] WrData;
  logic [7:0] RdData;
  logic       RdData_VLD;
  logic [7:0] TX_P_DATA;
  logic       TX_D_VLD;
  logic       TX_BUSY;
  logic       CMD_ERR;
  logic       OVR_ERR;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cmd  = 0;
  int exp_ovr  = 0;
  int obs_cmd  = 0;
  int obs_ovr  = 0;

  logic [11:0] q_wr[$];
  logic [3:0]  q_rd[$];
  logic [7:0]  q_tx[$];

  logic [7:0] rf_mem[16];
  logic       rf_respond;

  always #5 clk = ~clk;

  sys_ctrl_rx #(
    .CMD_WR(8'hAA),
    .CMD_RD(8'hBB),
    .RD_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .RST(RST),
    .RX_P_DATA(RX_P_DATA),
    .RX_D_VLD(RX_D_VLD),
    .WrEN(WrEN),
    .RdEN(RdEN),
    .Address(Address),
    .WrData(WrData),
    .RdData(RdData),
    .RdData_VLD(RdData_VLD),
    .TX_P_DATA(TX_P_DATA),
    .TX_D_VLD(TX_D_VLD),
    .TX_BUSY(TX_BUSY),
    .CMD_ERR(CMD_ERR),
    .OVR_ERR(OVR_ERR)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Register-file model: answers one cycle after RdEN when enabled
  always @(posedge clk or posedge RST) begin
    if (RST) begin
      RdData_VLD <= 1'b0;
      RdData     <= 8'h00;
    end else begin
      RdData_VLD <= RdEN & rf_respond;
      RdData     <= rf_mem[Address];
    end
  end

  // Monitor: pops expectations as the DUT produces accesses and transfers
  always @(negedge clk) begin
    if (WrEN && RdEN) check("wr_rd_exclusive", {WrEN, RdEN}, 2'b10);
    if (WrEN) begin
      if (q_wr.size() == 0) check("wr_queue", q_wr.size(), 1);
      else check("wr_access", {Address, WrData}, q_wr.pop_front());
    end
    if (RdEN) begin
      if (q_rd.size() == 0) check("rd_queue", q_rd.size(), 1);
      else check("rd_access", Address, q_rd.pop_front());
    end
    if (TX_D_VLD && !TX_BUSY) begin
      if (q_tx.size() == 0) check("tx_queue", q_tx.size(), 1);
      else check("tx_data", TX_P_DATA, q_tx.pop_front());
    end
    if (CMD_ERR) obs_cmd++;
    if (OVR_ERR) obs_ovr++;
  end

  // Called at posedge+1; strobe is valid for exactly the current cycle
  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(posedge clk);
    #1;
    RX_D_VLD  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST        = 1'b1;
    RX_P_DATA  = 8'h00;
    RX_D_VLD   = 1'b0;
    TX_BUSY    = 1'b0;
    rf_respond = 1'b1;
    for (int i = 0; i < 16; i++) rf_mem[i] = 8'(i * 17 + 3);
    rf_mem[2] = 8'h21;
    rf_mem[6] = 8'h9A;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {WrEN, RdEN, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR, OVR_ERR}, 32'h0);
    RST = 1'b0;
    idle(2);

    // Write frame with strobes three cycles apart
    q_wr.push_back({4'h3, 8'h5C});
    send_byte(8'hAA); idle(2);
    send_byte(8'h03); idle(2);
    send_byte(8'h5C);
    check("wr_pulse", {WrEN, RdEN}, 2'b10);
    idle(1);
    check("wr_pulse_end", WrEN, 1'b0);

    // Read frame, transmitter busy for five cycles
    TX_BUSY = 1'b1;
    q_rd.push_back(4'h2);
    q_tx.push_back(8'h21);
    send_byte(8'hBB);
    send_byte(8'h02);
    check("rd_pulse", {RdEN, WrEN}, 2'b10);
    idle(1);
    check("rd_pulse_end", {RdEN, TX_D_VLD}, 2'b00);
    idle(1);
    check("tx_vld_latency", TX_D_VLD, 1'b1);
    check("tx_data_direct", TX_P_DATA, 8'h21);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("tx_hold_busy", TX_D_VLD, 1'b1);
    end
    TX_BUSY = 1'b0;
    idle(1);
    check("tx_drop", TX_D_VLD, 1'b0);
    idle(2);

    // Overrun during TX_SEND
    TX_BUSY = 1'b1;
    q_rd.push_back(4'h6);
    q_tx.push_back(8'h9A);
    send_byte(8'hBB);
    send_byte(8'h06);
    idle(2);
    check("ovr_tx_vld", TX_D_VLD, 1'b1);
    exp_ovr++;
    send_byte(8'h33);
    check("ovr_pulse", OVR_ERR, 1'b1);
    check("ovr_tx_stable", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h9A});
    TX_BUSY = 1'b0;
    idle(1);
    check("ovr_tx_drop", {TX_D_VLD, OVR_ERR}, 2'b00);
    idle(2);

    // Unknown command, then a normal write right after
    exp_cmd++;
    send_byte(8'h7F);
    check("cmd_err_pulse", {CMD_ERR, WrEN, RdEN}, 3'b100);
    q_wr.push_back({4'h1, 8'hFF});
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'hFF);
    check("wr2_pulse", WrEN, 1'b1);
    // Next frame's command one cycle after WrEN
    idle(1);
    rf_respond = 1'b0;
    q_rd.push_back(4'h4);
    send_byte(8'hBB);
    send_byte(8'h04);
    check("to_rd_pulse", RdEN, 1'b1);
    for (int i = 1; i <= TO; i++) begin
      idle(1);
      check("to_no_early_ovr", OVR_ERR, 1'b0);
    end
    exp_ovr++;
    idle(1);
    check("to_ovr_pulse", OVR_ERR, 1'b1);
    idle(1);
    check("to_after", {OVR_ERR, TX_D_VLD}, 2'b00);
    rf_respond = 1'b1;

    // Reset in the middle of a write frame
    send_byte(8'hAA);
    send_byte(8'h05);
    check("pre_rst_addr", Address, 4'h5);
    #2 RST = 1'b1;
    #1;
    check("rst_async_outputs",
          {WrEN, RdEN, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR, OVR_ERR}, 32'h0);
    @(posedge clk);
    #1;
    RST = 1'b0;
    idle(1);
    exp_cmd++;
    send_byte(8'h05);
    check("post_rst_cmd_err", {CMD_ERR, WrEN}, 2'b10);
    idle(5);

    check("cmd_err_count", obs_cmd, exp_cmd);
    check("ovr_err_count", obs_ovr, exp_ovr);
    check("wr_queue_left", q_wr.size(), 0);
    check("rd_queue_left", q_rd.size(), 0);
    check("tx_queue_left", q_tx.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
